// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_if
// Description : Pipeline-to-sequencer signal bundle for hazard_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
    parameter int PERF_W = 16
);
    logic [4:0]        ID_rs;
    logic [4:0]        ID_rt;
    logic              ID_uses_rt;
    logic              ID_is_mdu;
    logic              ID_reads_hilo;
    logic              ID_EX_MemRead;
    logic [4:0]        ID_EX_rt;
    logic              EX_is_mdu;
    logic              EX_branch_taken;
    logic              pc_write;
    logic              IF_ID_write;
    logic              IF_ID_flush;
    logic              ID_EX_flush;
    logic              mdu_start;
    logic              mdu_busy;
    logic              mdu_done;
    logic [1:0]        stall_reason;
    logic [PERF_W-1:0] stall_cycles;

    // Pipeline side: supplies decode/EX status, consumes the enables.
    modport master (
        output ID_rs, ID_rt, ID_uses_rt, ID_is_mdu, ID_reads_hilo,
               ID_EX_MemRead, ID_EX_rt, EX_is_mdu, EX_branch_taken,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               mdu_start, mdu_busy, mdu_done, stall_reason, stall_cycles
    );

    // Controller side.
    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, ID_is_mdu, ID_reads_hilo,
               ID_EX_MemRead, ID_EX_rt, EX_is_mdu, EX_branch_taken,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               mdu_start, mdu_busy, mdu_done, stall_reason, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Load-use / MDU stall, branch flush and MDU sequencing control.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = 8,
    parameter int PERF_W      = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    hazard_stall_ctrl_if.slave  bus
);
    localparam logic [0:0]        S_IDLE     = 1'b0;
    localparam logic [0:0]        S_RUN      = 1'b1;
    localparam logic [CNT_W-1:0]  c_LOAD     = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0]  c_ONE      = CNT_W'(1);
    localparam logic [PERF_W-1:0] c_PERF_MAX = '1;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [0:0]        w_state;
    logic [PERF_W-1:0] r_stall_cycles;

    logic       w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_flush;
    logic       w_start, w_busy, w_done, w_lu, w_mh, w_stall, w_count;
    logic [1:0] w_reason;

    // The MDU state is implied by the busy counter.
    assign w_state = (r_cnt != '0) ? S_RUN : S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // A start request while running is ignored: the counter just keeps going.
    always_comb begin
        w_cnt_next = r_cnt;
        case (w_state)
            S_IDLE:  if (bus.EX_is_mdu) w_cnt_next = c_LOAD;
            S_RUN:   w_cnt_next = r_cnt - c_ONE;
            default: w_cnt_next = '0;
        endcase
    end

    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_start       = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        w_lu          = 1'b0;
        w_mh          = 1'b0;
        w_stall       = 1'b0;
        w_count       = 1'b0;
        w_reason      = 2'b00;
        if (!rst) begin
            w_start = (w_state == S_IDLE) && bus.EX_is_mdu;
            w_busy  = w_start || (w_state == S_RUN);
            w_done  = (r_cnt == c_ONE);
            w_lu    = bus.ID_EX_MemRead && (bus.ID_EX_rt != 5'd0) &&
                      ((bus.ID_EX_rt == bus.ID_rs) ||
                       (bus.ID_uses_rt && (bus.ID_EX_rt == bus.ID_rt)));
            w_mh    = w_busy && (bus.ID_is_mdu || bus.ID_reads_hilo);
            w_stall = w_lu || w_mh;
            // A taken branch squashes the stalled instruction anyway.
            if (bus.EX_branch_taken) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_stall) begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_id_ex_flush = 1'b1;
                w_reason      = {w_mh, w_lu};
                w_count       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_count && (r_stall_cycles != c_PERF_MAX)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.IF_ID_write  = w_if_id_write;
    assign bus.IF_ID_flush  = w_if_id_flush;
    assign bus.ID_EX_flush  = w_id_ex_flush;
    assign bus.mdu_start    = w_start;
    assign bus.mdu_busy     = w_busy;
    assign bus.mdu_done     = w_done;
    assign bus.stall_reason = w_reason;
    assign bus.stall_cycles = rst ? '0 : r_stall_cycles;
endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed-vector scoreboard bench for hazard_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // Packed expectation: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
    //                      mdu_start, mdu_busy, mdu_done, stall_reason, stall_cycles}
    logic [24:0] sb[$];

    hazard_stall_ctrl_if #(.PERF_W(16)) bus ();

    hazard_stall_ctrl #(
        .MDU_LATENCY(4),
        .CNT_W      (8),
        .PERF_W     (16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic imdu, input logic hilo,
                        input logic mr, input logic [4:0] exrt, input logic exmdu,
                        input logic br, input logic chk, input logic [24:0] e);
        @(posedge clk);
        #1;
        rst                 = r;
        bus.ID_rs           = rs;
        bus.ID_rt           = rt;
        bus.ID_uses_rt      = urt;
        bus.ID_is_mdu       = imdu;
        bus.ID_reads_hilo   = hilo;
        bus.ID_EX_MemRead   = mr;
        bus.ID_EX_rt        = exrt;
        bus.EX_is_mdu       = exmdu;
        bus.EX_branch_taken = br;
        if (chk) sb.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle with a queued
    // expectation presents a result at the falling edge.
    initial begin
        logic [24:0] act, e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {bus.pc_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_flush,
                       bus.mdu_start, bus.mdu_busy, bus.mdu_done, bus.stall_reason,
                       bus.stall_cycles};
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL vec%0d outputs: got %b_%b_%0d, want %b_%b_%0d",
                             n_vec, act[24:18], act[17:16], act[15:0],
                             e[24:18], e[17:16], e[15:0]);
                end
            end
        end
    end

    localparam logic [6:0] c_RUN  = 7'b1100000;  // free-running
    localparam logic [6:0] c_STL  = 7'b0001000;  // stalled
    localparam logic [6:0] c_BR   = 7'b1111000;  // branch flush

    initial begin
        bus.ID_rs = '0; bus.ID_rt = '0; bus.ID_uses_rt = 1'b0; bus.ID_is_mdu = 1'b0;
        bus.ID_reads_hilo = 1'b0; bus.ID_EX_MemRead = 1'b0; bus.ID_EX_rt = '0;
        bus.EX_is_mdu = 1'b0; bus.EX_branch_taken = 1'b0;

        // Reset: outputs forced even with hazards and an MDU request present
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd0});
        step(1, 8, 0, 0, 0, 1, 1, 8, 1, 0, 1, {c_RUN, 2'b00, 16'd0});
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd0});

        // Load-use on rs, then rt register 0, then rt gating
        step(0, 8, 0, 0, 0, 0, 1, 8, 0, 0, 1, {c_STL, 2'b01, 16'd0});
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd1});
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd1});
        step(0, 3, 9, 0, 0, 0, 1, 9, 0, 0, 1, {c_RUN, 2'b00, 16'd1});
        step(0, 3, 9, 1, 0, 0, 1, 9, 0, 0, 1, {c_STL, 2'b01, 16'd1});
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd2});

        // MDU op with mfhi held in ID: stall t..t+3, release at t+4
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, {7'b0001110, 2'b10, 16'd2});
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {7'b0001010, 2'b10, 16'd3});
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {7'b0001010, 2'b10, 16'd4});
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {7'b0001011, 2'b10, 16'd5});
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd6});

        // Both hazards, then branch override mid-run, then illegal restart
        step(0, 8, 0, 0, 1, 0, 1, 8, 1, 0, 1, {7'b0001110, 2'b11, 16'd6});
        step(0, 8, 0, 0, 1, 0, 1, 8, 0, 1, 1, {7'b1111010, 2'b00, 16'd7});
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, {7'b0001010, 2'b10, 16'd7});
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, {7'b0001011, 2'b10, 16'd8});
        // Second start exactly MDU_LATENCY cycles after the first
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, {7'b1100110, 2'b00, 16'd9});

        // Reset at cnt=2 abandons the op without a done pulse
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {7'b1100010, 2'b00, 16'd9});
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd0});
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd0});
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd0});

        // Saturation: 65535 load-use stalls, then more must not wrap
        for (int i = 0; i < 65535; i++)
            step(0, 8, 0, 0, 0, 0, 1, 8, 0, 0, 0, '0);
        step(0, 8, 0, 0, 0, 0, 1, 8, 0, 0, 1, {c_STL, 2'b01, 16'd65535});
        step(0, 8, 0, 0, 0, 0, 1, 8, 0, 0, 1, {c_STL, 2'b01, 16'd65535});
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {c_RUN, 2'b00, 16'd65535});

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU. It sits beside the ALU-input forwarding logic and owns the PC and IF/ID enables and the IF/ID and ID/EX flushes.
- It detects load-use hazards, which forwarding cannot cover, and inserts one bubble for each.
- It schedules the shared multi-cycle multiply/divide unit (MDU) with a busy counter, and stalls dependent or competing ID instructions until the MDU result is ready.
- Taken branches resolved in EX flush the younger stages.

Parameters:
- MDU_LATENCY, 32, cycles the MDU occupies from start to result-valid. Legal range 2..255.
- CNT_W, 8, width of the MDU busy counter. Must satisfy 2^CNT_W > MDU_LATENCY.
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_uses_rt  in  1  ID instruction reads rt as a source
- ID_is_mdu  in  1  ID instruction is mult/multu/div/divu
- ID_reads_hilo  in  1  ID instruction is mfhi/mflo
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_rt  in  5  destination register of the load in EX
- EX_is_mdu  in  1  valid MDU instruction currently in EX
- EX_branch_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC register enable
- IF_ID_write  out  1  IF/ID register enable
- IF_ID_flush  out  1  IF/ID register loads a NOP
- ID_EX_flush  out  1  ID/EX register loads a bubble (all control bits 0)
- mdu_start  out  1  one-cycle start pulse to the MDU
- mdu_busy  out  1  MDU occupied
- mdu_done  out  1  one-cycle pulse in the last busy cycle
- stall_reason  out  2  00 none, 01 load-use, 10 MDU, 11 both
- stall_cycles  out  PERF_W  saturating count of stall cycles

Behaviour:
- Reset: while rst=1, and after the edge on which rst is sampled:
  - cnt=0, stall_cycles=0.
  - Outputs are forced to pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_flush=0, mdu_start=0, mdu_busy=0, mdu_done=0, stall_reason=00.
  - Reset mid-MDU abandons the operation with no mdu_done pulse.
- MDU counter (register cnt; states IDLE when cnt=0, RUN when cnt!=0):
  - mdu_start = EX_is_mdu && cnt==0. On the start edge, cnt <= MDU_LATENCY-1.
  - In RUN, cnt decrements by 1 each cycle down to 0. When cnt==1, the next state is IDLE.
  - mdu_busy = mdu_start || cnt!=0. For a start in cycle t, busy is high for cycles t..t+MDU_LATENCY-1.
  - mdu_done = (cnt==1), i.e. high in cycle t+MDU_LATENCY-1.
  - EX_is_mdu while cnt!=0 is a protocol violation: it is ignored, with no restart and no counter change.
- Load-use hazard (lu), combinational:
  - Condition: ID_EX_MemRead && ID_EX_rt!=0 && (ID_EX_rt==ID_rs || (ID_uses_rt && ID_EX_rt==ID_rt)).
  - Exactly one bubble per load, because the load leaves EX on the next edge.
- MDU hazard (mh): mdu_busy && (ID_is_mdu || ID_reads_hilo). An ID instruction dependent on an MDU op started in the same cycle also stalls.
- Stall = lu || mh, with EX_branch_taken=0:
  - pc_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0.
  - stall_reason = {mh, lu}.
- Branch priority: EX_branch_taken=1 overrides any stall.
  - pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1, stall_reason=00.
  - The MDU counter is unaffected, because the EX instruction is committed.
- Otherwise: pc_write=1, IF_ID_write=1, both flushes 0.
- stall_cycles:
  - Increments on each edge where the stall condition holds (branch not taken, rst=0).
  - Saturates at 2^PERF_W-1 and never wraps.
- Latency: all control outputs are combinational from the current inputs and cnt. Only cnt and stall_cycles are registered.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_rt=8, ID_rs=8 -> one cycle of pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_reason=01, stall_cycles 0->1. With ID_EX_rt=0 -> no stall.
- rt gating: ID_EX_rt=9, ID_rt=9, ID_uses_rt=0 -> no stall. With ID_uses_rt=1 -> stall.
- MDU sequencing: MDU_LATENCY=4, EX_is_mdu pulse at t, ID_reads_hilo=1 held.
  - mdu_start at t only.
  - mdu_busy for t..t+3.
  - mdu_done at t+3.
  - Stall t..t+3 with stall_reason=10, release at t+4, stall_cycles=4.
- Simultaneous: load-use and MDU hazards together -> stall_reason=11. Adding EX_branch_taken=1 in the same cycle -> both flushes=1, pc_write=1, stall_cycles unchanged.
- Back-to-back MDU: ID_is_mdu stalled while busy. A second start occurs only at t+MDU_LATENCY. EX_is_mdu injected mid-run -> no mdu_start, cnt continues.
- Reset mid-run at cnt=2 -> next cycle cnt=0, mdu_busy=0, no mdu_done, stall_cycles=0. Saturation: force 65535 stall cycles -> stall_cycles holds at 65535.
